// File: rtl/aes_ctr_ctrl.sv
// CTR-mode front end for an AES encrypt core: issues the counter block, waits for
// the keystream, and returns din XOR keystream on a valid/ready output stream.
module aes_ctr_ctrl #(
   parameter int unsigned CTR_W   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         iv_load,
   input  logic [127:0] iv,
   input  logic         din_valid,
   input  logic [127:0] din,
   output logic         din_ready,
   output logic         dout_valid,
   output logic [127:0] dout,
   input  logic         dout_ready,
   output logic         aes_pt_valid,
   output logic [127:0] aes_pt,
   input  logic         aes_ct_rdy,
   input  logic [127:0] aes_ct,
   output logic         busy,
   output logic         err
);

   typedef enum logic [2:0] {
      IDLE_NOIV,
      READY,
      ISSUE,
      WAIT,
      OUT
   } state_t;

   // Mask of the incrementing low field; works unchanged for CTR_W = 128.
   localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CTR_W);
   localparam logic [7:0]   TMO      = 8'(TIMEOUT);

   state_t       state, state_nx;
   logic [127:0] ctr, ctr_nx;
   logic [127:0] data, data_nx;
   logic [127:0] dout_q, dout_nx;
   logic         err_q, err_nx;
   logic         armed, armed_nx;
   logic [7:0]   tcnt, tcnt_nx;
   logic [127:0] ctr_inc;

   assign ctr_inc = (ctr & ~LOW_MASK) | ((ctr + 128'd1) & LOW_MASK);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE_NOIV;
         ctr    <= '0;
         data   <= '0;
         dout_q <= '0;
         err_q  <= 1'b0;
         armed  <= 1'b0;
         tcnt   <= '0;
      end else begin
         state  <= state_nx;
         ctr    <= ctr_nx;
         data   <= data_nx;
         dout_q <= dout_nx;
         err_q  <= err_nx;
         armed  <= armed_nx;
         tcnt   <= tcnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      ctr_nx       = ctr;
      data_nx      = data;
      dout_nx      = dout_q;
      err_nx       = err_q;
      armed_nx     = armed;
      tcnt_nx      = tcnt;
      din_ready    = 1'b0;
      aes_pt_valid = 1'b0;
      dout_valid   = 1'b0;
      unique case (state)
         IDLE_NOIV: begin
            if (iv_load) begin
               ctr_nx   = iv;
               err_nx   = 1'b0;
               state_nx = READY;
            end
         end
         READY: begin
            // A reload wins over data, so din is not accepted in that cycle.
            din_ready = !iv_load;
            if (iv_load) begin
               ctr_nx = iv;
               err_nx = 1'b0;
            end else if (din_valid) begin
               data_nx  = din;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            aes_pt_valid = 1'b1;
            armed_nx     = 1'b0;
            tcnt_nx      = '0;
            state_nx     = WAIT;
         end
         WAIT: begin
            // A ready level only counts once it has been seen low in this block.
            if (armed && aes_ct_rdy) begin
               dout_nx  = data ^ aes_ct;
               ctr_nx   = ctr_inc;
               state_nx = OUT;
            end else begin
               if (!aes_ct_rdy) armed_nx = 1'b1;
               tcnt_nx = tcnt + 8'd1;
               if (tcnt_nx == TMO) begin
                  err_nx   = 1'b1;
                  state_nx = IDLE_NOIV;
               end
            end
         end
         OUT: begin
            dout_valid = 1'b1;
            if (dout_ready) state_nx = READY;
         end
         default: state_nx = IDLE_NOIV;
      endcase
   end

   assign dout   = dout_q;
   assign aes_pt = ctr;
   assign err    = err_q;
   assign busy   = (state == ISSUE) || (state == WAIT) || (state == OUT);

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Scoreboard bench for aes_ctr_ctrl: a reference counter model predicts aes_pt and
// dout; a monitor pops and compares whenever the DUT presents them.
module tb_aes_ctr_ctrl;

   localparam int unsigned CTR_W   = 32;
   localparam int unsigned TIMEOUT = 20;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         iv_load = 1'b0;
   logic [127:0] iv = '0;
   logic         din_valid = 1'b0;
   logic [127:0] din = '0;
   logic         din_ready;
   logic         dout_valid;
   logic [127:0] dout;
   logic         dout_ready;
   logic         aes_pt_valid;
   logic [127:0] aes_pt;
   logic         aes_ct_rdy;
   logic [127:0] aes_ct;
   logic         busy;
   logic         err;

   aes_ctr_ctrl #(.CTR_W(CTR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv),
      .din_valid(din_valid), .din(din), .din_ready(din_ready),
      .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
      .aes_pt_valid(aes_pt_valid), .aes_pt(aes_pt),
      .aes_ct_rdy(aes_ct_rdy), .aes_ct(aes_ct),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int last_pt_cyc = 0;

   logic [127:0] pt_q[$];
   logic [127:0] dout_q[$];
   logic [127:0] m_ctr = '0;

   int aes_mode = 0;   // 0: respond, 1: never respond
   int lat  = 4;
   int hold = 0;
   int bp_mode = 0;    // 0: random, 1: stall, 2: always ready

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chkb(input string name, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Stand-in block cipher: any fixed bijective-looking mix suffices here.
   function automatic logic [127:0] aes_e(input logic [127:0] x);
      return x ^ {x[94:0], x[127:95]} ^ {x[60:0], x[127:61]} ^ 128'h5A17_C3E9_0F2D_B486_7E11_9C40_D2A8_3B65;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Counter advance from the rule: low 32-bit field counts modulo 2^32.
   function automatic logic [127:0] next_ctr(input logic [127:0] c);
      longint unsigned lo;
      lo = (longint'(c[31:0]) + 64'd1) % (64'd1 << 32);
      return {c[127:32], lo[31:0]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      dout_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       dout_ready = ($urandom_range(0, 3) != 0);
            1:       dout_ready = 1'b0;
            default: dout_ready = 1'b1;
         endcase
      end
   end

   // AES core model: drops ready after the start pulse (optionally after holding the
   // stale level for a few cycles), then presents E(pt) with ready high and leaves it up.
   initial begin : aes_model
      logic [127:0] pt;
      aes_ct_rdy = 1'b0;
      aes_ct     = '0;
      forever begin
         @(negedge clk);
         if (aes_pt_valid && !reset) begin
            pt = aes_pt;
            if (aes_mode == 1) begin
               @(posedge clk);
               #1 aes_ct_rdy = 1'b0;
            end else begin
               repeat (hold) @(posedge clk);
               @(posedge clk);
               #1 aes_ct_rdy = 1'b0;
               aes_ct = rnd128();
               repeat (lat) @(posedge clk);
               #1 aes_ct = aes_e(pt);
               aes_ct_rdy = 1'b1;
            end
         end
      end
   end

   initial begin : monitor
      logic         held_v;
      logic [127:0] held_d;
      held_v = 1'b0;
      held_d = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held_v = 1'b0;
         end else begin
            if (aes_pt_valid) begin
               last_pt_cyc = cyc;
               if (pt_q.size() == 0) fail("unexpected_aes_pt_valid");
               else chk("aes_pt", aes_pt, pt_q.pop_front());
            end
            if (dout_valid) begin
               if (held_v) chk("dout_hold", dout, held_d);
               if (dout_ready) begin
                  if (dout_q.size() == 0) fail("unexpected_dout");
                  else chk("dout", dout, dout_q.pop_front());
                  held_v = 1'b0;
               end else begin
                  held_v = 1'b1;
                  held_d = dout;
               end
            end else begin
               if (held_v) fail("dout_valid_dropped_before_accept");
               held_v = 1'b0;
            end
         end
      end
   end

   task automatic wait_accept(input logic [127:0] d, input bit expect_out);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (din_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("din_accept_timeout");
      else begin
         pt_q.push_back(m_ctr);
         if (expect_out) begin
            dout_q.push_back(d ^ aes_e(m_ctr));
            m_ctr = next_ctr(m_ctr);
         end
      end
      @(posedge clk);
      #1 din_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d, input bit expect_out);
      @(posedge clk);
      #1 din = d;
      din_valid = 1'b1;
      wait_accept(d, expect_out);
   endtask

   task automatic load_iv(input logic [127:0] v);
      @(posedge clk);
      #1 iv = v;
      iv_load = 1'b1;
      @(posedge clk);
      #1 iv_load = 1'b0;
      m_ctr = v;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (pt_q.size() == 0 && dout_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("drain_timeout");
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chkb({tag, "_din_ready"}, din_ready, 1'b0);
      chkb({tag, "_dout_valid"}, dout_valid, 1'b0);
      chk({tag, "_dout"}, dout, '0);
      chkb({tag, "_aes_pt_valid"}, aes_pt_valid, 1'b0);
      chk({tag, "_aes_pt"}, aes_pt, '0);
      chkb({tag, "_busy"}, busy, 1'b0);
      chkb({tag, "_err"}, err, 1'b0);
   endtask

   initial begin : main
      logic [127:0] d;
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      din_valid = 1'b1;
      @(negedge clk);
      chkb("noiv_din_ready", din_ready, 1'b0);
      @(posedge clk);
      #1 din_valid = 1'b0;

      // Known IV, zero data, 10-cycle core latency; second block uses low word ...0E10.
      bp_mode = 2;
      lat = 10;
      hold = 0;
      load_iv(128'h000102030405060708090A0B0C0D0E0F);
      send_block('0, 1'b1);
      send_block(rnd128(), 1'b1);
      drain();

      // Stale ready: level stays high into WAIT before dropping and rising again.
      lat = 4;
      hold = 3;
      send_block(rnd128(), 1'b1);
      drain();

      // Randomized traffic with random latency, stale-ready holds and backpressure.
      bp_mode = 0;
      load_iv(rnd128());
      for (int k = 0; k < 20; k++) begin
         lat  = $urandom_range(1, 12);
         hold = $urandom_range(0, 3);
         send_block(rnd128(), 1'b1);
      end
      drain();

      // Low-field wrap with no carry into the upper bits.
      hold = 0;
      lat = 2;
      d = rnd128();
      d[31:0] = 32'hFFFF_FFFF;
      load_iv(d);
      send_block(rnd128(), 1'b1);
      send_block(rnd128(), 1'b1);
      drain();

      // Reload together with din_valid in READY: block must use the new IV.
      bp_mode = 2;
      d = rnd128();
      @(posedge clk);
      #1 iv = rnd128();
      iv_load = 1'b1;
      din = d;
      din_valid = 1'b1;
      @(posedge clk);
      #1 iv_load = 1'b0;
      m_ctr = iv;
      wait_accept(d, 1'b1);
      drain();

      // Output stall: dout stays, nothing else accepted or issued.
      bp_mode = 1;
      lat = 3;
      send_block(rnd128(), 1'b1);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dout_valid) break;
         n++;
      end
      if (n == 50) fail("stall_dout_valid_timeout");
      @(posedge clk);
      #1 din_valid = 1'b1;
      din = rnd128();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chkb("stall_dout_valid", dout_valid, 1'b1);
         chkb("stall_din_ready", din_ready, 1'b0);
         chkb("stall_aes_pt_valid", aes_pt_valid, 1'b0);
         chkb("stall_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1 din_valid = 1'b0;
      bp_mode = 2;
      drain();

      // Core never answers: error after TIMEOUT WAIT cycles, back to no-IV idle.
      aes_mode = 1;
      send_block(rnd128(), 1'b0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (err) break;
         n++;
      end
      if (!err) fail("timeout_err_never_set");
      else chk("timeout_cycles", 128'(cyc - last_pt_cyc), 128'(TIMEOUT + 1));
      chkb("timeout_din_ready", din_ready, 1'b0);
      chkb("timeout_busy", busy, 1'b0);
      @(negedge clk);
      chkb("timeout_err_sticky", err, 1'b1);
      aes_mode = 0;
      load_iv(rnd128());
      @(negedge clk);
      chkb("ivload_clears_err", err, 1'b0);
      chkb("ivload_din_ready", din_ready, 1'b1);
      lat = 5;
      send_block(rnd128(), 1'b1);
      drain();

      // Reset while waiting on the core: block discarded, later ready ignored.
      lat = 30;
      send_block(rnd128(), 1'b0);
      repeat (5) @(negedge clk);
      chkb("midwait_busy", busy, 1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dout_valid || aes_pt_valid) n++;
      end
      chk("postreset_no_output", 128'(n), '0);
      lat = 3;
      load_iv(rnd128());
      send_block(rnd128(), 1'b1);
      drain();

      chk("pt_queue_empty", 128'(pt_q.size()), '0);
      chk("dout_queue_empty", 128'(dout_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit");
      $fatal(1);
   end

endmodule
